// File: rtl/filling_line_ctrl.sv
// Multi-lane bottle filling controller: per-lane MOVE/FILL/SEAL/INSPECT FSMs sharing a cork stock and batch counter.
// Optional `JAM_DETECT_EN: the lane timer also runs in MOVE and faults a lane that never sees a bottle.

module filling_lane #(
    parameter int FILL_TIMEOUT = 1000
) (
    input  logic CLK,
    input  logic reset,
    input  logic running,
    input  logic bottle_present,
    input  logic full,
    input  logic approved,
    input  logic rejected,
    input  logic clear_fault,
    input  logic grant,
    input  logic appr_win,
    output logic seal_req,
    output logic appr_req,
    output logic motor,
    output logic valve,
    output logic fill_alarm,
    output logic discard
);
    localparam int TW = $clog2(FILL_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, MOVE, FILL, SEAL, INSPECT, FAULT} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            discard_q, discard_d;
    logic            timeout, timed;

    assign timeout = (timer_q == TW'(FILL_TIMEOUT - 1));
`ifdef JAM_DETECT_EN
    assign timed = (state_q == FILL) || (state_q == MOVE);
`else
    assign timed = (state_q == FILL);
`endif

    always_comb begin
        state_d   = state_q;
        discard_d = 1'b0;
        case (state_q)
            IDLE:    if (running) state_d = MOVE;
            MOVE: begin
                if (bottle_present) state_d = FILL;
`ifdef JAM_DETECT_EN
                else if (timeout)   state_d = FAULT;
`endif
            end
            // Bottle removal outranks a full reading taken the same cycle.
            FILL: begin
                if (!bottle_present) state_d = FAULT;
                else if (full)       state_d = SEAL;
                else if (timeout)    state_d = FAULT;
            end
            SEAL:    if (grant) state_d = INSPECT;
            INSPECT: begin
                if (rejected || appr_win) begin
                    discard_d = rejected;
                    state_d   = running ? MOVE : IDLE;
                end
            end
            FAULT:   if (clear_fault) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timer restarts on every state change, so it reads zero on the first cycle of FILL.
    assign timer_d = (timed && (state_d == state_q)) ? timer_q + TW'(1) : '0;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            discard_q <= discard_d;
        end
    end

    assign seal_req   = (state_q == SEAL);
    assign appr_req   = (state_q == INSPECT) && approved && !rejected;
    assign motor      = (state_q == MOVE);
    assign valve      = (state_q == FILL);
    assign fill_alarm = (state_q == FAULT);
    assign discard    = discard_q;
endmodule

module filling_line_ctrl #(
    parameter int LANES        = 2,
    parameter int BATCH_SIZE   = 12,
    parameter int FILL_TIMEOUT = 1000,
    parameter int STOCK_W      = 8,
    parameter int CNT_W        = 8
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          start_stop,
    input  logic                          add_stock,
    input  logic [LANES-1:0]              bottle_present,
    input  logic [LANES-1:0]              full,
    input  logic [LANES-1:0]              approved,
    input  logic [LANES-1:0]              rejected,
    input  logic [LANES-1:0]              clear_fault,
    output logic                          running,
    output logic [LANES-1:0]              motor,
    output logic [LANES-1:0]              valve,
    output logic [LANES-1:0]              discard,
    output logic [LANES-1:0]              fill_alarm,
    output logic                          no_stock_alarm,
    output logic [STOCK_W-1:0]            stock_level,
    output logic [$clog2(BATCH_SIZE)-1:0] good_count,
    output logic [CNT_W-1:0]              batch_count,
    output logic                          batch_done
);
    localparam int GW = $clog2(BATCH_SIZE);
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

    logic               running_q, running_d;
    logic [STOCK_W-1:0] stock_q, stock_d;
    logic [GW-1:0]      good_q, good_d;
    logic [CNT_W-1:0]   batch_q, batch_d;
    logic               done_q, done_d;
    logic [PW-1:0]      ptr_q, ptr_d;

    logic [LANES-1:0]   seal_req, appr_req, grant, appr_win;
    logic               gnt_found;
    logic [PW-1:0]      gnt_idx, rr_idx;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        filling_lane #(.FILL_TIMEOUT(FILL_TIMEOUT)) u_lane (
            .CLK(CLK), .reset(reset), .running(running_q),
            .bottle_present(bottle_present[l]), .full(full[l]),
            .approved(approved[l]), .rejected(rejected[l]), .clear_fault(clear_fault[l]),
            .grant(grant[l]), .appr_win(appr_win[l]),
            .seal_req(seal_req[l]), .appr_req(appr_req[l]),
            .motor(motor[l]), .valve(valve[l]), .fill_alarm(fill_alarm[l]), .discard(discard[l])
        );
    end

    // Round-robin scan starting at the pointer; no grant at all while stock is empty.
    always_comb begin
        grant     = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_idx    = '0;
        for (int i = 0; i < LANES; i++) begin
            rr_idx = PW'((int'(ptr_q) + i) % LANES);
            if (!gnt_found && seal_req[rr_idx] && (stock_q != '0)) begin
                grant[rr_idx] = 1'b1;
                gnt_idx       = rr_idx;
                gnt_found     = 1'b1;
            end
        end
    end

    assign ptr_d    = gnt_found ? PW'((int'(gnt_idx) + 1) % LANES) : ptr_q;
    assign appr_win = appr_req & (~appr_req + LANES'(1));

    always_comb begin
        stock_d = stock_q;
        if (gnt_found && !add_stock)
            stock_d = stock_q - STOCK_W'(1);
        else if (add_stock && !gnt_found && (stock_q != '1))
            stock_d = stock_q + STOCK_W'(1);
    end

    always_comb begin
        good_d  = good_q;
        batch_d = batch_q;
        done_d  = 1'b0;
        if (|appr_win) begin
            if (good_q == GW'(BATCH_SIZE - 1)) begin
                good_d  = '0;
                batch_d = batch_q + CNT_W'(1);
                done_d  = 1'b1;
            end else begin
                good_d  = good_q + GW'(1);
            end
        end
    end

    assign running_d = running_q ^ start_stop;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            running_q <= 1'b0;
            stock_q   <= '0;
            good_q    <= '0;
            batch_q   <= '0;
            done_q    <= 1'b0;
            ptr_q     <= '0;
        end else begin
            running_q <= running_d;
            stock_q   <= stock_d;
            good_q    <= good_d;
            batch_q   <= batch_d;
            done_q    <= done_d;
            ptr_q     <= ptr_d;
        end
    end

    assign running        = running_q;
    assign stock_level    = stock_q;
    assign good_count     = good_q;
    assign batch_count    = batch_q;
    assign batch_done     = done_q;
    assign no_stock_alarm = (|seal_req) && (stock_q == '0);
endmodule

// File: tb/tb_filling_line_ctrl.sv
// Bench for filling_line_ctrl: directed scenarios plus a randomized run against a per-cycle behavioural model.
module tb_filling_line_ctrl;
    localparam int LANES = 2, BS = 12, FT = 16, SW = 4, CW = 2;
    localparam int GW = $clog2(BS);
    localparam int SMAX = (1 << SW) - 1;
    localparam int P_IDLE = 10, P_MOVE = 11, P_FILL = 12, P_SEAL = 13, P_INSP = 14, P_FAULT = 15;

    logic CLK = 1'b0, reset = 1'b0, start_stop = 1'b0, add_stock = 1'b0;
    logic [LANES-1:0] bottle_present = '0, full = '0, approved = '0, rejected = '0, clear_fault = '0;
    logic running, no_stock_alarm, batch_done;
    logic [LANES-1:0] motor, valve, discard, fill_alarm;
    logic [SW-1:0] stock_level;
    logic [GW-1:0] good_count;
    logic [CW-1:0] batch_count;

    int n_pass = 0, n_total = 0;

    filling_line_ctrl #(.LANES(LANES), .BATCH_SIZE(BS), .FILL_TIMEOUT(FT), .STOCK_W(SW), .CNT_W(CW)) dut (
        .CLK(CLK), .reset(reset), .start_stop(start_stop), .add_stock(add_stock),
        .bottle_present(bottle_present), .full(full), .approved(approved), .rejected(rejected),
        .clear_fault(clear_fault), .running(running), .motor(motor), .valve(valve), .discard(discard),
        .fill_alarm(fill_alarm), .no_stock_alarm(no_stock_alarm), .stock_level(stock_level),
        .good_count(good_count), .batch_count(batch_count), .batch_done(batch_done));

    always #5 CLK = ~CLK;

    // Reference model: lane phases, cycles spent in phase, total approvals since reset.
    int m_ph [LANES];
    int m_age [LANES];
    int m_stock, m_total, m_ptr;
    bit m_run, m_done;
    bit [LANES-1:0] m_disc;

    always @(posedge CLK or negedge reset) begin : model
        int g, w, idx;
        int nph [LANES];
        if (!reset) begin
            for (int k = 0; k < LANES; k++) begin m_ph[k] <= P_IDLE; m_age[k] <= 0; end
            m_stock <= 0; m_total <= 0; m_ptr <= 0; m_run <= 0; m_done <= 0; m_disc <= '0;
        end else begin
            g = -1;
            if (m_stock > 0)
                for (int k = 0; k < LANES; k++) begin
                    idx = (m_ptr + k) % LANES;
                    if (g < 0 && m_ph[idx] == P_SEAL) g = idx;
                end
            w = -1;
            for (int k = LANES - 1; k >= 0; k--)
                if (m_ph[k] == P_INSP && approved[k] && !rejected[k]) w = k;
            for (int k = 0; k < LANES; k++) begin
                nph[k] = m_ph[k];
                case (m_ph[k])
                    P_IDLE: if (m_run) nph[k] = P_MOVE;
                    P_MOVE: begin
                        if (bottle_present[k]) nph[k] = P_FILL;
`ifdef JAM_DETECT_EN
                        else if (m_age[k] == FT - 1) nph[k] = P_FAULT;
`endif
                    end
                    P_FILL: if (!bottle_present[k]) nph[k] = P_FAULT;
                            else if (full[k]) nph[k] = P_SEAL;
                            else if (m_age[k] == FT - 1) nph[k] = P_FAULT;
                    P_SEAL: if (g == k) nph[k] = P_INSP;
                    P_INSP: if (rejected[k] || w == k) nph[k] = m_run ? P_MOVE : P_IDLE;
                    default: if (clear_fault[k]) nph[k] = P_IDLE;
                endcase
                m_disc[k] <= (m_ph[k] == P_INSP) && rejected[k];
                m_age[k]  <= (nph[k] == m_ph[k]) ? m_age[k] + 1 : 0;
                m_ph[k]   <= nph[k];
            end
            if (g >= 0 && !add_stock) m_stock <= m_stock - 1;
            else if (g < 0 && add_stock) m_stock <= (m_stock < SMAX) ? m_stock + 1 : SMAX;
            m_done  <= (w >= 0) && (m_total % BS == BS - 1);
            m_total <= m_total + ((w >= 0) ? 1 : 0);
            if (g >= 0) m_ptr <= (g + 1) % LANES;
            m_run <= m_run ^ start_stop;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clear_inputs();
        start_stop = 0; add_stock = 0;
        bottle_present = '0; full = '0; approved = '0; rejected = '0; clear_fault = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0; #1; step(1);
        reset = 1;
    endtask

    task automatic test_reset();
        start_stop = 1; add_stock = 1; step(1);
        start_stop = 0; step(3);
        reset = 0; #1;
        n_total++;
        if ({running, motor, valve, discard, fill_alarm, no_stock_alarm, stock_level, good_count, batch_count, batch_done} !== 21'd0)
            $display("FAIL reset_outputs got=%0h exp=0", {running, motor, valve, discard, fill_alarm, no_stock_alarm, stock_level, good_count, batch_count, batch_done});
        else n_pass++;
        step(1); reset = 1; clear_inputs(); step(1);
        n_total++;
        if (stock_level !== 4'd0 || running !== 1'b0) $display("FAIL reset_release got=%0d/%0b exp=0/0", stock_level, running);
        else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        add_stock = 1; step(3); add_stock = 0;
        n_total++; if (stock_level !== 4'd3) $display("FAIL basic_stock3 got=%0d exp=3", stock_level); else n_pass++;
        start_stop = 1; step(1); start_stop = 0;
        n_total++; if (running !== 1'b1 || motor[0] !== 1'b0) $display("FAIL basic_run got=%b%b exp=10", running, motor[0]); else n_pass++;
        step(1);
        n_total++; if (motor[0] !== 1'b1) $display("FAIL basic_motor_on got=%b exp=1", motor[0]); else n_pass++;
        bottle_present = 2'b01; step(1);
        n_total++; if ({motor[0], valve[0]} !== 2'b01) $display("FAIL basic_fill got=%b exp=01", {motor[0], valve[0]}); else n_pass++;
        full = 2'b01; step(1); full = 0;
        n_total++; if (valve[0] !== 1'b0) $display("FAIL basic_valve_off got=%b exp=0", valve[0]); else n_pass++;
        step(1);
        n_total++; if (stock_level !== 4'd2) $display("FAIL basic_stock2 got=%0d exp=2", stock_level); else n_pass++;
        approved = 2'b01; step(1); approved = 0; bottle_present = 0;
        n_total++; if (good_count !== 4'd1 || motor[0] !== 1'b1) $display("FAIL basic_count got=%0d/%b exp=1/1", good_count, motor[0]); else n_pass++;
    endtask

    task automatic test_arbiter();
        do_reset();
        add_stock = 1; start_stop = 1; step(1); add_stock = 0; start_stop = 0;
        step(1);
        bottle_present = 2'b11; step(1);
        full = 2'b11; step(1); full = 0;
        n_total++; if ({stock_level, no_stock_alarm} !== {4'd1, 1'b0}) $display("FAIL arb_both_seal got=%0d/%b exp=1/0", stock_level, no_stock_alarm); else n_pass++;
        step(1);
        n_total++; if ({stock_level, no_stock_alarm} !== {4'd0, 1'b1}) $display("FAIL arb_first_grant got=%0d/%b exp=0/1", stock_level, no_stock_alarm); else n_pass++;
        add_stock = 1; step(1); add_stock = 0;
        n_total++; if ({stock_level, no_stock_alarm} !== {4'd1, 1'b0}) $display("FAIL arb_add_no_grant got=%0d/%b exp=1/0", stock_level, no_stock_alarm); else n_pass++;
        step(1);
        n_total++; if ({stock_level, no_stock_alarm} !== {4'd0, 1'b0}) $display("FAIL arb_second_grant got=%0d/%b exp=0/0", stock_level, no_stock_alarm); else n_pass++;
        approved = 2'b11; step(1);
        n_total++; if (good_count !== 4'd1) $display("FAIL arb_slot_one got=%0d exp=1", good_count); else n_pass++;
        step(1); approved = 0;
        n_total++; if (good_count !== 4'd2) $display("FAIL arb_slot_two got=%0d exp=2", good_count); else n_pass++;
    endtask

    task automatic test_timeout();
        int cnt = 0;
        do_reset();
        start_stop = 1; step(1); start_stop = 0;
        step(1);
        bottle_present = 2'b01; step(1);
        while (valve[0] && cnt < 40) begin cnt++; step(1); end
        n_total++; if (cnt !== 16 || fill_alarm[0] !== 1'b1) $display("FAIL timeout_len got=%0d/%b exp=16/1", cnt, fill_alarm[0]); else n_pass++;
        clear_fault = 2'b01; step(1); clear_fault = 0;
        n_total++; if ({fill_alarm[0], valve[0]} !== 2'b00) $display("FAIL timeout_clear got=%b exp=00", {fill_alarm[0], valve[0]}); else n_pass++;
        bottle_present = 0;
    endtask

    task automatic test_both_qc();
        do_reset();
        add_stock = 1; start_stop = 1; step(1); add_stock = 0; start_stop = 0;
        step(1);
        bottle_present = 2'b01; step(1);
        full = 2'b01; step(1); full = 0;
        step(1);
        approved = 2'b01; rejected = 2'b01; step(1); approved = 0; rejected = 0; bottle_present = 0;
        n_total++; if (discard !== 2'b01 || good_count !== 4'd0) $display("FAIL qc_both got=%b/%0d exp=01/0", discard, good_count); else n_pass++;
        step(1);
        n_total++; if (discard !== 2'b00) $display("FAIL qc_pulse got=%b exp=00", discard); else n_pass++;
    endtask

    task automatic test_batch();
        int dones = 0, prev_good = 0, cyc = 0;
        do_reset();
        start_stop = 1; add_stock = 1; bottle_present = 2'b01; full = 2'b01; approved = 2'b01;
        step(1); start_stop = 0;
        while (dones < 4 && cyc < 400) begin
            step(1); cyc++;
            if (batch_done) begin
                dones++;
                n_total++;
                if (good_count !== 4'd0 || prev_good !== 11 || batch_count !== CW'(dones % 4))
                    $display("FAIL batch_wrap got=%0d/%0d/%0d exp=0/11/%0d", good_count, prev_good, batch_count, dones % 4);
                else n_pass++;
            end
            prev_good = int'(good_count);
        end
        clear_inputs();
        n_total++; if (dones !== 4) $display("FAIL batch_count_done got=%0d exp=4", dones); else n_pass++;
        step(1);
        n_total++; if (batch_done !== 1'b0) $display("FAIL batch_done_pulse got=%b exp=0", batch_done); else n_pass++;
    endtask

    task automatic test_stop();
        do_reset();
        add_stock = 1; start_stop = 1; step(1); add_stock = 0; start_stop = 0;
        step(1);
        bottle_present = 2'b01; step(1);
        start_stop = 1; step(1); start_stop = 0;
        n_total++; if ({running, valve[0]} !== 2'b01) $display("FAIL stop_in_fill got=%b exp=01", {running, valve[0]}); else n_pass++;
        full = 2'b01; step(1); full = 0;
        step(1);
        approved = 2'b01; step(1); approved = 0; bottle_present = 0;
        n_total++; if (good_count !== 4'd1 || motor[0] !== 1'b0) $display("FAIL stop_finish got=%0d/%b exp=1/0", good_count, motor[0]); else n_pass++;
        step(5);
        n_total++; if ({motor[0], valve[0]} !== 2'b00) $display("FAIL stop_parked got=%b exp=00", {motor[0], valve[0]}); else n_pass++;
    endtask

    task automatic test_jam();
        int cnt = 0;
        do_reset();
        start_stop = 1; step(1); start_stop = 0;
        step(1);
        while (motor[0] && cnt < 40) begin cnt++; step(1); end
`ifdef JAM_DETECT_EN
        n_total++; if (cnt !== 16 || fill_alarm[0] !== 1'b1) $display("FAIL jam_fault got=%0d/%b exp=16/1", cnt, fill_alarm[0]); else n_pass++;
`else
        n_total++; if (cnt !== 40 || fill_alarm[0] !== 1'b0) $display("FAIL move_waits got=%0d/%b exp=40/0", cnt, fill_alarm[0]); else n_pass++;
`endif
    endtask

    task automatic test_stock();
        do_reset();
        add_stock = 1; step(20); add_stock = 0;
        n_total++; if (stock_level !== 4'd15) $display("FAIL stock_saturate got=%0d exp=15", stock_level); else n_pass++;
        do_reset();
        add_stock = 1; step(3); add_stock = 0;
        start_stop = 1; step(1); start_stop = 0;
        step(1);
        bottle_present = 2'b01; step(1);
        full = 2'b01; step(1); full = 0;
        add_stock = 1; step(1); add_stock = 0;
        n_total++; if (stock_level !== 4'd3) $display("FAIL stock_add_grant got=%0d exp=3", stock_level); else n_pass++;
        step(1);
        n_total++; if (stock_level !== 4'd3) $display("FAIL stock_single_grant got=%0d exp=3", stock_level); else n_pass++;
        bottle_present = 0;
    endtask

    task automatic test_random();
        logic [LANES-1:0] e_mot, e_val, e_flt;
        bit e_nsa;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            start_stop = ($urandom_range(0, 99) < 4);
            add_stock  = ($urandom_range(0, 99) < 35);
            for (int l = 0; l < LANES; l++) begin
                bottle_present[l] = ($urandom_range(0, 99) < 85);
                full[l]           = ($urandom_range(0, 99) < 25);
                approved[l]       = ($urandom_range(0, 99) < 40);
                rejected[l]       = ($urandom_range(0, 99) < 15);
                clear_fault[l]    = ($urandom_range(0, 99) < 10);
            end
            if ($urandom_range(0, 499) == 0) begin reset = 0; step(1); reset = 1; end
            else step(1);
            e_nsa = 0;
            for (int l = 0; l < LANES; l++) begin
                e_mot[l] = (m_ph[l] == P_MOVE);
                e_val[l] = (m_ph[l] == P_FILL);
                e_flt[l] = (m_ph[l] == P_FAULT);
                if (m_ph[l] == P_SEAL && m_stock == 0) e_nsa = 1;
            end
            n_total++;
            if ({motor, valve, fill_alarm, discard} !== {e_mot, e_val, e_flt, m_disc})
                $display("FAIL rand_lanes c=%0d got=%b exp=%b", c, {motor, valve, fill_alarm, discard}, {e_mot, e_val, e_flt, m_disc});
            else n_pass++;
            n_total++;
            if ({running, no_stock_alarm, batch_done} !== {m_run, e_nsa, m_done})
                $display("FAIL rand_flags c=%0d got=%b exp=%b", c, {running, no_stock_alarm, batch_done}, {m_run, e_nsa, m_done});
            else n_pass++;
            n_total++;
            if ({stock_level, good_count, batch_count} !== {SW'(m_stock), GW'(m_total % BS), CW'((m_total / BS) % 4)})
                $display("FAIL rand_counts c=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c, stock_level, good_count, batch_count,
                         m_stock, m_total % BS, (m_total / BS) % 4);
            else n_pass++;
        end
        clear_inputs();
    endtask

    initial begin
        reset = 0; step(2); reset = 1;
        test_reset();
        test_basic();
        test_arbiter();
        test_timeout();
        test_both_qc();
        test_batch();
        test_stop();
        test_jam();
        test_stock();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/filling_line_ctrl.md
Name: filling_line_ctrl

Overview:
- Parametrised multi-lane successor to the single-lane bottle filling controller.
- LANES identical lanes, each with its own conveyor/fill/seal/inspect FSM, sharing one cork stock counter through a round-robin arbiter.
- Approved bottles feed a shared batch counter with configurable BATCH_SIZE, replacing the fixed dozen.
- Sits between the debouncer/edge-detector front end and the 7-segment display logic; all inputs are already debounced and synchronous to CLK.

Parameters:
- LANES, 2, number of independent filling lanes (1..8).
- BATCH_SIZE, 12, approved bottles per batch.
- FILL_TIMEOUT, 1000, max CLK cycles in FILL (and, with JAM_DETECT_EN, in MOVE) before fault.
- STOCK_W, 8, width of cork stock counter.
- CNT_W, 8, width of batch counter.

Ports:
- CLK input 1 system clock, rising edge.
- reset input 1 asynchronous, active-low reset.
- start_stop input 1 one-cycle pulse; toggles run request.
- add_stock input 1 one-cycle pulse; adds one cork to stock.
- bottle_present input LANES bottle under filler, per lane.
- full input LANES fill level sensor, per lane.
- approved input LANES QC pass, per lane.
- rejected input LANES QC fail, per lane.
- clear_fault input LANES one-cycle pulse; releases lane from FAULT.
- running output 1 run request state.
- motor output LANES conveyor motor, per lane.
- valve output LANES fill valve, per lane.
- discard output LANES one-cycle eject pulse, per lane.
- fill_alarm output LANES lane in FAULT.
- no_stock_alarm output 1 some lane waiting in SEAL with stock==0.
- stock_level output STOCK_W current cork count.
- good_count output $clog2(BATCH_SIZE) approved bottles in current batch.
- batch_count output CNT_W completed batches.
- batch_done output 1 one-cycle pulse on batch completion.

Behaviour:
- Reset (reset=0, async): all lanes IDLE; running=0, stock_level=0, good_count=0, batch_count=0, arbiter pointer=0; every output 0.
- running toggles on each start_stop pulse, 1-cycle latency.
- Lane outputs are Moore decodes of lane state: motor=(MOVE), valve=(FILL), fill_alarm=(FAULT). discard is registered, high exactly one cycle after the INSPECT reject transition.
- Lane FSM:
  - IDLE: running=1 -> MOVE.
  - MOVE: bottle_present=1 -> FILL.
  - FILL: full=1 -> SEAL. bottle_present=0 -> FAULT (bottle removal; full ignored that cycle). Timer==FILL_TIMEOUT-1 -> FAULT. Timer clears on FILL entry.
  - SEAL: raises request. On grant with stock_level>0 -> INSPECT and stock decrements by 1.
  - INSPECT: rejected=1 -> discard, exit. approved=1 and approval slot won -> count, exit. Both high: rejected wins, no count. Exit goes to MOVE if running=1, else IDLE.
  - FAULT: held until clear_fault -> IDLE.
- Stop (running->0): lanes already past IDLE finish the current bottle, then park in IDLE. Reset mid-operation returns immediately to reset state.
- Cork arbiter:
  - Round-robin among SEAL lanes; at most one grant per cycle, only when stock_level>0.
  - Pointer moves to granted lane+1 mod LANES.
  - add_stock and grant in the same cycle: stock unchanged. A grant needs stock_level>0 before the add.
  - add_stock saturates at 2^STOCK_W-1.
- no_stock_alarm=1 whenever any lane is in SEAL and stock_level==0 (combinational from registers).
- Approval slot: one approval per cycle, lowest lane index wins. Losing lanes stay in INSPECT.
- Counting: good_count increments per approval. At BATCH_SIZE-1 plus an approval: good_count->0, batch_count+1 (wraps modulo 2^CNT_W), batch_done pulses the same cycle the count updates.

Optional Feature:
- JAM_DETECT_EN defined: the lane timer also runs in MOVE. Reaching FILL_TIMEOUT-1 without bottle_present -> FAULT (fill_alarm raised).
- Undefined: MOVE waits indefinitely; timer logic exists only for FILL.

Test Plan:
- Reset, add_stock x3, start_stop, lane0 bottle_present, full, approved -> motor0 1 then 0, valve0 1 for fill duration, stock_level 3->2, good_count 1.
- LANES=2, stock=1, both lanes enter SEAL the same cycle, pointer=0 -> lane0 granted, stock 0, no_stock_alarm=1 for lane1. Then add_stock -> lane1 granted next cycle.
- FILL_TIMEOUT=16, full never asserted -> valve high 16 cycles, then fill_alarm=1. clear_fault -> IDLE, fill_alarm=0.
- approved and rejected high together in INSPECT -> discard 1 cycle, good_count unchanged.
- 12 approvals (BATCH_SIZE=12) -> good_count wraps 11->0, batch_count 0->1, batch_done single pulse. With CNT_W=2, 4 batches -> batch_count 3->0.
- start_stop during FILL -> running=0. Lane finishes through INSPECT, returns to IDLE, motor stays 0. With JAM_DETECT_EN, MOVE without bottle for 16 cycles -> FAULT.
